// File: rtl/security_pkg.sv
// Shared definitions for the security command arbiter: the command codes on the
// alarm FSM WiFi bus, the legal-code screen and the arbiter state encoding.
package security_pkg;

  localparam logic [3:0] CMD_IDLE   = 4'b0000;
  localparam logic [3:0] CMD_DISARM = 4'b1010;
  localparam logic [3:0] CMD_REARM  = 4'b1011;
  localparam logic [3:0] CMD_PANIC  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2,
    LOCK = 2'd3
  } arb_state_t;

  // Only these three codes may ever reach the alarm FSM.
  function automatic logic cmd_is_legal(input logic [3:0] code);
    return (code == CMD_DISARM) || (code == CMD_REARM) || (code == CMD_PANIC);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above the pointer wins,
// otherwise the search wraps to the lowest-numbered requester.
module rr_arbiter #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Wrap candidate first (lowest valid overall), then override with the lowest valid
  // at or above the pointer if one exists.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j]) begin
        idx = IDW'(j);
        any = 1'b1;
      end
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j >= int'(ptr))) begin
        idx = IDW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      grant[j] = any && (idx == IDW'(j));
    end
  end

endmodule

// File: rtl/security_cmd_arbiter.sv
// Round-robin arbiter sharing the 4-bit alarm command bus among N_REQ requesters.
// Accepted legal codes are driven for HOLD_CYCLES, followed by GAP_CYCLES of CMD_IDLE.
// Illegal codes are consumed with a one-cycle reject pulse.
// Optional feature macro SECCMD_LOCKOUT_EN: MAX_BAD consecutive rejects lock the bus
// for LOCKOUT_CYCLES cycles.
//
//   state | meaning
//   IDLE  | arbitrating, req_ready live, cmd_out = CMD_IDLE
//   HOLD  | driving the accepted command, cmd_valid = 1
//   GAP   | idle gap after a hold window, cmd_out = CMD_IDLE
//   LOCK  | lockout after repeated rejects (SECCMD_LOCKOUT_EN only)
module security_cmd_arbiter
  import security_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int HOLD_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int MAX_BAD        = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [4*N_REQ-1:0]       req_cmd,
  output logic [N_REQ-1:0]         req_ready,
  output logic [3:0]               cmd_out,
  output logic                     cmd_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     reject,
  output logic                     busy,
  output logic                     locked
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic [IDW-1:0] grant_id_nxt;
  logic [3:0]     cmd_q, cmd_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           reject_nxt;

  logic [N_REQ-1:0] pick_grant;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [3:0]       sel_cmd;
  logic             accept;

`ifdef SECCMD_LOCKOUT_EN
  localparam int BW = $clog2(MAX_BAD + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;
  logic [BW-1:0] bad_cnt, bad_nxt;
  logic [LW-1:0] lock_cnt, lock_nxt;
`endif

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Mux the winning requester's code using the one-hot grant.
  always_comb begin
    sel_cmd = CMD_IDLE;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) sel_cmd = req_cmd[4*i +: 4];
    end
  end

  assign accept    = (state == IDLE) && pick_any;
  assign req_ready = (state == IDLE) ? pick_grant : '0;

  // Bus outputs decode straight from the state so an async reset drops them at once.
  assign cmd_out   = (state == HOLD) ? cmd_q : CMD_IDLE;
  assign cmd_valid = (state == HOLD);
  assign busy      = (state != IDLE);
`ifdef SECCMD_LOCKOUT_EN
  assign locked    = (state == LOCK);
`else
  assign locked    = 1'b0;
`endif

  // Next-state, pointer, counters and reject pulse.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    grant_id_nxt = grant_id;
    cmd_nxt      = cmd_q;
    cnt_nxt      = cnt;
    reject_nxt   = 1'b0;
`ifdef SECCMD_LOCKOUT_EN
    bad_nxt      = bad_cnt;
    lock_nxt     = lock_cnt;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          ptr_nxt      = (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          grant_id_nxt = pick_idx;
          if (cmd_is_legal(sel_cmd)) begin
            state_nxt = HOLD;
            cmd_nxt   = sel_cmd;
            cnt_nxt   = CW'(HOLD_CYCLES - 1);
`ifdef SECCMD_LOCKOUT_EN
            bad_nxt   = '0;
`endif
          end else begin
            reject_nxt = 1'b1;
`ifdef SECCMD_LOCKOUT_EN
            if (int'(bad_cnt) + 1 >= MAX_BAD) begin
              state_nxt = LOCK;
              lock_nxt  = LW'(LOCKOUT_CYCLES - 1);
              bad_nxt   = '0;
            end else begin
              bad_nxt = bad_cnt + 1'b1;
            end
`endif
          end
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      LOCK: begin
`ifdef SECCMD_LOCKOUT_EN
        if (lock_cnt == '0) state_nxt = IDLE;
        else                lock_nxt  = lock_cnt - 1'b1;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      cmd_q    <= CMD_IDLE;
      cnt      <= '0;
      reject   <= 1'b0;
`ifdef SECCMD_LOCKOUT_EN
      bad_cnt  <= '0;
      lock_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_id <= grant_id_nxt;
      cmd_q    <= cmd_nxt;
      cnt      <= cnt_nxt;
      reject   <= reject_nxt;
`ifdef SECCMD_LOCKOUT_EN
      bad_cnt  <= bad_nxt;
      lock_cnt <= lock_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_security_cmd_arbiter.sv
// Bench for security_cmd_arbiter: directed scenarios plus a randomized phase, with a
// timeline-based reference model checking every output on every cycle.
module tb_security_cmd_arbiter;

  localparam int N  = 3;
  localparam int H  = 4;
  localparam int G  = 2;
  localparam int MB = 3;
  localparam int LC = 10;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [4*N-1:0] req_cmd = '0;
  logic [N-1:0]   req_ready;
  logic [3:0]     cmd_out;
  logic           cmd_valid;
  logic [1:0]     grant_id;
  logic           reject;
  logic           busy;
  logic           locked;

  security_cmd_arbiter #(
    .N_REQ          (N),
    .HOLD_CYCLES    (H),
    .GAP_CYCLES     (G),
    .MAX_BAD        (MB),
    .LOCKOUT_CYCLES (LC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_ready (req_ready),
    .cmd_out   (cmd_out),
    .cmd_valid (cmd_valid),
    .grant_id  (grant_id),
    .reject    (reject),
    .busy      (busy),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [3:0] c);
    return (c == 4'hA) || (c == 4'hB) || (c == 4'hC);
  endfunction

  // Reference model: cycle numbers at which each window ends.
  int m_n = 0;
  int m_ptr = 0;
  int m_gid = 0;
  int m_hold_end = -1;
  int m_busy_end = -1;
  int m_lock_end = -1;
  int m_reject_at = -100;
  int m_bad = 0;
  logic [3:0] m_cmd = 4'h0;

  always @(negedge clk) begin : model_cmp
    int win;
    logic [N-1:0] exp_ready;
    logic [3:0] code;
    m_n++;
    if (!reset) begin
      m_ptr = 0; m_gid = 0; m_hold_end = -1; m_busy_end = -1;
      m_lock_end = -1; m_reject_at = -100; m_bad = 0;
      chk("rst_cmd_out", cmd_out, 0);
      chk("rst_cmd_valid", cmd_valid, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_reject", reject, 0);
      chk("rst_busy", busy, 0);
      chk("rst_locked", locked, 0);
    end else begin
      win = -1;
      if (m_n > m_busy_end) begin
        for (int k = 0; k < N; k++)
          if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      chk("m_req_ready", req_ready, exp_ready);
      chk("m_cmd_out", cmd_out, (m_n <= m_hold_end) ? m_cmd : 4'h0);
      chk("m_cmd_valid", cmd_valid, m_n <= m_hold_end);
      chk("m_busy", busy, m_n <= m_busy_end);
      chk("m_locked", locked, m_n <= m_lock_end);
      chk("m_reject", reject, m_n == m_reject_at);
      chk("m_grant_id", grant_id, m_gid);
      if (win >= 0) begin
        code  = req_cmd[4*win +: 4];
        m_gid = win;
        m_ptr = (win + 1) % N;
        if (legal(code)) begin
          m_cmd      = code;
          m_hold_end = m_n + H;
          m_busy_end = m_n + H + G;
          m_bad      = 0;
        end else begin
          m_reject_at = m_n + 1;
          m_bad++;
`ifdef SECCMD_LOCKOUT_EN
          if (m_bad >= MB) begin
            m_lock_end = m_n + LC;
            m_busy_end = m_n + LC;
            m_bad      = 0;
          end
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b0;
    req_valid = '0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [3:0] c);
    req_cmd[4*i +: 4] = c;
    req_valid[i] = 1'b1;
  endtask

  // Wait for a transfer; returns the winner and its cycle, leaves time at T+1 (+1ns).
  task automatic wait_any(output int who, output int at);
    who = -1;
    at  = -1;
    for (int k = 0; k < 40 && who < 0; k++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) begin
        for (int i = N - 1; i >= 0; i--)
          if (req_valid[i] && req_ready[i]) who = i;
        at = cyc;
        step();
        req_valid[who] = 1'b0;
      end else begin
        step();
      end
    end
    if (who < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no transfer expected one within 40 cycles");
    end
  endtask

  logic [3:0] legal_codes [3] = '{4'hA, 4'hB, 4'hC};
  logic [3:0] t6_codes [5] = '{4'hF, 4'hF, 4'hB, 4'hF, 4'hF};

  initial begin
    int who, at, prev;
    logic [N-1:0] acc;
    logic [3:0] c;

    // 1: single DISARM, hold then gap
    do_reset();
    set_req(0, 4'hA);
    @(negedge clk);
    chk("t1_ready", req_ready, 3'b001);
    step();
    req_valid[0] = 1'b0;
    for (int k = 0; k < H; k++) begin
      @(negedge clk);
      chk("t1_hold_cmd", cmd_out, 4'hA);
      chk("t1_hold_valid", cmd_valid, 1);
      chk("t1_hold_busy", busy, 1);
      step();
    end
    for (int k = 0; k < G; k++) begin
      @(negedge clk);
      chk("t1_gap_cmd", cmd_out, 4'h0);
      chk("t1_gap_valid", cmd_valid, 0);
      chk("t1_gap_busy", busy, 1);
      step();
    end
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);
    step();

    // 2: three simultaneous requests served 0,1,2, seven cycles apart
    do_reset();
    set_req(0, 4'hB);
    set_req(1, 4'hC);
    set_req(2, 4'hA);
    prev = 0;
    for (int g = 0; g < 3; g++) begin
      wait_any(who, at);
      chk("t2_order", who, g);
      @(negedge clk);
      chk("t2_grant_id", grant_id, g);
      if (g > 0) chk("t2_spacing", at - prev, 7);
      prev = at;
      step();
    end
    repeat (8) step();

    // 3: illegal code rejected, next requester accepted the following cycle
    do_reset();
    set_req(1, 4'h6);
    set_req(2, 4'hB);
    wait_any(who, at);
    chk("t3_first", who, 1);
    @(negedge clk);
    chk("t3_reject", reject, 1);
    chk("t3_cmd_idle", cmd_out, 4'h0);
    chk("t3_ready2", req_ready, 3'b100);
    step();
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("t3_reject_end", reject, 0);
    chk("t3_cmd2", cmd_out, 4'hB);
    step();
    repeat (8) step();

    // 4: reset in the second hold cycle
    do_reset();
    set_req(0, 4'hC);
    wait_any(who, at);
    step();
    reset = 1'b0;
    #1;
    chk("t4_cmd_drop", cmd_out, 4'h0);
    chk("t4_valid_drop", cmd_valid, 0);
    step();
    step();
    reset = 1'b1;
    set_req(0, 4'hA);
    set_req(1, 4'hB);
    set_req(2, 4'hC);
    wait_any(who, at);
    chk("t4_winner", who, 0);
    req_valid = '0;
    repeat (10) step();

`ifdef SECCMD_LOCKOUT_EN
    // 5: three consecutive rejects lock the bus for LC cycles
    do_reset();
    for (int r = 0; r < 3; r++) begin
      set_req(0, 4'hF);
      wait_any(who, at);
      @(negedge clk);
      chk("t5_reject", reject, 1);
      chk("t5_locked", locked, r == 2);
      step();
    end
    set_req(0, 4'hA);
    for (int k = 0; k < LC - 1; k++) begin
      @(negedge clk);
      chk("t5_lock_hold", locked, 1);
      chk("t5_lock_ready", req_ready, 3'b000);
      step();
    end
    @(negedge clk);
    chk("t5_unlocked", locked, 0);
    chk("t5_ready_after", req_ready, 3'b001);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t5_cmd_after", cmd_out, 4'hA);
    step();
    repeat (8) step();

    // 6: a legal code between rejects clears the bad count
    do_reset();
    for (int r = 0; r < 5; r++) begin
      set_req(0, t6_codes[r]);
      wait_any(who, at);
      @(negedge clk);
      chk("t6_no_lock", locked, 0);
      step();
      if (t6_codes[r] == 4'hB) repeat (8) step();
    end
    repeat (4) step();
`endif

    // Randomized phase, model checks every cycle
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      acc = reset ? (req_valid & req_ready) : '0;
      step();
      req_valid = req_valid & ~acc;
      reset = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 1) c = legal_codes[$urandom_range(0, 2)];
          else                           c = 4'($urandom);
          set_req(i, c);
        end
      end
    end
    reset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
